lc3_datapath_gen: RTL and testbench
===================================

LC3_DATAPATH_GEN -- requirements
Module: lc3_datapath_gen

Interface
REQ-001 Parameters SHALL be: DW, default 16, datapath/bus width; NREG, default 8, register count (power of 2, >=2); RAW, default log2(NREG), register-address width; TO, default 15, memory-handshake timeout in cycles (>=1).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 aluControl  in  2  ALU op select.
REQ-005 SR1, SR2, DR  in  RAW each  register-file read/write addresses.
REQ-006 selPC  in  2; selEAB2  in  2; selEAB1, selMAR, selMDR  in  1 each  mux selects.
REQ-007 enaALU, enaMARM, enaPC, enaMDR  in  1 each  bus-driver enables.
REQ-008 regWE, flagWE, ldPC, ldIR, ldMAR, ldMDR, memWE  in  1 each  load/write strobes.
REQ-009 mem_addr, mem_wdata  out  DW each; mem_rdata  in  DW  external memory data.
REQ-010 mem_req, mem_we  out  1; mem_ack  in  1  memory request/acknowledge handshake.
REQ-011 IR_out  out  DW; N, Z, P  out  1 each; busy  out  1; bus_err  out  1 (sticky).

Function
REQ-012 Internal bus SHALL carry the one enabled source (ALU, MARMux, PC, MDR); zero enables -> bus = 0; two or more enables -> bus = 0 and bus_err set for that cycle onward.
REQ-013 ALU: 00 ADD, 01 AND, 10 NOT Ra, 11 pass Ra; operand B = sext(IR[4:0]) to DW when IR[5]=1, else Rb; results mod 2^DW.
REQ-014 EAB = (selEAB1 ? Ra : PC) + {00: 0, 01: sext IR[5:0], 10: sext IR[8:0], 11: sext IR[10:0]}, mod 2^DW.
REQ-015 MARMux = selMAR ? EAB : zext IR[7:0].
REQ-016 PC on ldPC: selPC 00 -> PC+1 (wraps at 2^DW-1 to 0), 01 -> EAB, 10 -> bus, 11 -> PC held.
REQ-017 ldIR, ldMAR load bus; ldMDR with selMDR=0 loads bus; regWE writes bus to R[DR]; reads of Ra/Rb combinational from current state.
REQ-018 flagWE: N=bus[DW-1], Z=(bus==0), P=otherwise; exactly one flag set at all times.
REQ-019 Memory FSM states IDLE, ACCESS: IDLE -> ACCESS on ldMDR&selMDR (read) or memWE (write; memWE wins if both); ACCESS -> IDLE on mem_ack or timeout.
REQ-020 In ACCESS: mem_req=1, mem_addr=MAR, mem_wdata=MDR, mem_we=1 for write, busy=1; outputs driven from registers, not bus.
REQ-021 Read ack: MDR <= mem_rdata in ack cycle; ack in first ACCESS cycle allowed (1-cycle min latency); mem_ack in IDLE ignored.
REQ-022 Wait counter SHALL count ACCESS cycles; at TO cycles without ack -> abort, MDR unchanged, bus_err set, return IDLE.
REQ-023 While busy=1 every ld*, regWE, flagWE, memWE strobe SHALL be ignored; bus and combinational outputs still evaluate.
REQ-024 IR_out = IR.

Reset
REQ-025 reset low at an edge: PC, IR, MAR, MDR, all registers = 0; N=0, Z=1, P=0; FSM IDLE; counter 0; busy, mem_req, mem_we, bus_err = 0; in-flight access abandoned; all strobes ignored that cycle.
REQ-026 bus_err clears only on reset.

Structure
REQ-027 Shared package SHALL hold aluControl/selPC/selEAB2 encodings and the memory-FSM state type.
REQ-028 One sub-module, lc3_regfile_gen (NREG x DW, 2 read, 1 write), SHALL be instantiated; everything else inline.

Verification
REQ-029 DW=16: R1=5, IR[5:0]=6'b111101 (imm -3), ADD, enaALU, regWE DR=2, flagWE -> R2=0x0002, P=1.
REQ-030 MAR=0x3000, read, mem_ack after 3 cycles with 0xBEEF -> busy high 3 cycles, MDR=0xBEEF, then ldIR via enaMDR -> IR_out=0xBEEF.
REQ-031 enaPC and enaALU together -> bus 0, bus_err=1, stays 1 until reset.
REQ-032 Read with no ack, TO=15 -> busy 15 cycles, MDR unchanged, bus_err=1, IDLE.
REQ-033 PC=0xFFFF, ldPC selPC=00 -> PC=0x0000; reset low during ACCESS -> mem_req=0, Z=1 next cycle.
REQ-034 DW=32, NREG=16: write R15=0x80000000 with flagWE -> N=1, Ra(SR1=15)=0x80000000.

Source files
------------

// File: rtl/lc3_datapath_gen_pkg.sv
// Shared encodings for the LC-3 style datapath: ALU ops, PC and EAB
// mux selects, and the memory-handshake FSM state type.
package lc3_datapath_gen_pkg;

    typedef enum logic [1:0] {
        AluAdd  = 2'b00,
        AluAnd  = 2'b01,
        AluNot  = 2'b10,
        AluPass = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        PcInc  = 2'b00,
        PcEab  = 2'b01,
        PcBus  = 2'b10,
        PcHold = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        EabOffZero = 2'b00,
        EabOff6    = 2'b01,
        EabOff9    = 2'b10,
        EabOff11   = 2'b11
    } eab2_sel_e;

    typedef enum logic {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } mem_state_e;

    // Number of sources that may drive the internal bus.
    localparam int unsigned BusSrcs = 4;

endpackage

// File: rtl/lc3_datapath_gen_if.sv
// External memory request/acknowledge bundle. The datapath is the master,
// the memory is the slave.
interface lc3_datapath_gen_if #(
    parameter int unsigned DW = 16
) ();
    import lc3_datapath_gen_pkg::*;

    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_req;
    logic          mem_we;
    logic          mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_req,
        output mem_we,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_req,
        input  mem_we,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/lc3_regfile_gen.sv
// NREG x DW register file: two combinational read ports, one synchronous
// write port, synchronous active-low clear of every entry.
module lc3_regfile_gen
    import lc3_datapath_gen_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8,
    parameter int unsigned RAW  = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_we,
    input  logic [RAW-1:0] i_waddr,
    input  logic [DW-1:0]  i_wdata,
    input  logic [RAW-1:0] i_raddr_a,
    input  logic [RAW-1:0] i_raddr_b,
    output logic [DW-1:0]  o_rdata_a,
    output logic [DW-1:0]  o_rdata_b
);

    logic [DW-1:0] r_mem [NREG];

    // Clear all entries on reset, otherwise write the addressed entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/lc3_datapath_gen.sv
// LC-3 style datapath: shared internal bus, ALU, EAB adder, MAR mux, PC,
// IR, MAR, MDR, condition codes and a two-state memory handshake with a
// wait-cycle timeout. Every strobe is ignored while a memory access runs.
module lc3_datapath_gen
    import lc3_datapath_gen_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8,
    parameter int unsigned RAW  = $clog2(NREG),
    parameter int unsigned TO   = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     i_aluControl,
    input  logic [RAW-1:0] i_SR1,
    input  logic [RAW-1:0] i_SR2,
    input  logic [RAW-1:0] i_DR,
    input  logic [1:0]     i_selPC,
    input  logic [1:0]     i_selEAB2,
    input  logic           i_selEAB1,
    input  logic           i_selMAR,
    input  logic           i_selMDR,
    input  logic           i_enaALU,
    input  logic           i_enaMARM,
    input  logic           i_enaPC,
    input  logic           i_enaMDR,
    input  logic           i_regWE,
    input  logic           i_flagWE,
    input  logic           i_ldPC,
    input  logic           i_ldIR,
    input  logic           i_ldMAR,
    input  logic           i_ldMDR,
    input  logic           i_memWE,
    lc3_datapath_gen_if.master mem,
    output logic [DW-1:0]  o_IR_out,
    output logic           o_N,
    output logic           o_Z,
    output logic           o_P,
    output logic           o_busy,
    output logic           o_bus_err
);

    // Wait counter holds 0 .. TO-1.
    localparam int unsigned CW = (TO > 1) ? $clog2(TO) : 1;

    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_mar;
    logic [DW-1:0] r_mdr;
    logic          r_n;
    logic          r_z;
    logic          r_p;
    logic          r_bus_err;
    mem_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_wr;

    mem_state_e    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_wr_nxt;
    logic          w_rd_done;
    logic          w_timeout;
    logic          w_idle;

    logic [DW-1:0] w_ra;
    logic [DW-1:0] w_rb;
    logic [DW-1:0] w_sext5;
    logic [DW-1:0] w_sext6;
    logic [DW-1:0] w_sext9;
    logic [DW-1:0] w_sext11;
    logic [DW-1:0] w_opb;
    logic [DW-1:0] w_alu;
    logic [DW-1:0] w_eab_base;
    logic [DW-1:0] w_eab_off;
    logic [DW-1:0] w_eab;
    logic [DW-1:0] w_marmux;
    logic [DW-1:0] w_bus;
    logic [BusSrcs-1:0] w_ena;
    logic          w_conflict;

    assign w_idle = (r_state == StIdle);

    lc3_regfile_gen #(
        .DW   (DW),
        .NREG (NREG),
        .RAW  (RAW)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_we      (i_regWE && w_idle),
        .i_waddr   (i_DR),
        .i_wdata   (w_bus),
        .i_raddr_a (i_SR1),
        .i_raddr_b (i_SR2),
        .o_rdata_a (w_ra),
        .o_rdata_b (w_rb)
    );

    assign w_sext5  = {{(DW-5){r_ir[4]}}, r_ir[4:0]};
    assign w_sext6  = {{(DW-6){r_ir[5]}}, r_ir[5:0]};
    assign w_sext9  = {{(DW-9){r_ir[8]}}, r_ir[8:0]};
    assign w_sext11 = {{(DW-11){r_ir[10]}}, r_ir[10:0]};

    // ALU: IR[5] picks the immediate form of operand B.
    always_comb begin
        w_opb = r_ir[5] ? w_sext5 : w_rb;
        w_alu = '0;
        unique case (alu_op_e'(i_aluControl))
            AluAdd:  w_alu = w_ra + w_opb;
            AluAnd:  w_alu = w_ra & w_opb;
            AluNot:  w_alu = ~w_ra;
            AluPass: w_alu = w_ra;
        endcase
    end

    // Effective-address adder and MAR mux.
    always_comb begin
        w_eab_base = i_selEAB1 ? w_ra : r_pc;
        w_eab_off  = '0;
        unique case (eab2_sel_e'(i_selEAB2))
            EabOffZero: w_eab_off = '0;
            EabOff6:    w_eab_off = w_sext6;
            EabOff9:    w_eab_off = w_sext9;
            EabOff11:   w_eab_off = w_sext11;
        endcase
        w_eab    = w_eab_base + w_eab_off;
        w_marmux = i_selMAR ? w_eab : {{(DW-8){1'b0}}, r_ir[7:0]};
    end

    // Bus: exactly one enabled source drives it; none or several give zero.
    always_comb begin
        w_ena      = {i_enaALU, i_enaMARM, i_enaPC, i_enaMDR};
        w_conflict = ($countones(w_ena) > 1);
        w_bus      = '0;
        case (w_ena)
            4'b1000: w_bus = w_alu;
            4'b0100: w_bus = w_marmux;
            4'b0010: w_bus = r_pc;
            4'b0001: w_bus = r_mdr;
            default: w_bus = '0;
        endcase
    end

    // Memory FSM next state: write wins over read; ack beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_nxt    = r_wr;
        w_rd_done   = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_memWE) begin
                    w_state_nxt = StAccess;
                    w_wr_nxt    = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (i_ldMDR && i_selMDR) begin
                    w_state_nxt = StAccess;
                    w_wr_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            StAccess: begin
                if (mem.mem_ack) begin
                    w_state_nxt = StIdle;
                    w_rd_done   = !r_wr;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CW'(TO - 1)) begin
                    w_state_nxt = StIdle;
                    w_timeout   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    // Memory FSM state register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wr    <= w_wr_nxt;
        end
    end

    // Architectural registers; strobes only take effect while idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_n       <= 1'b0;
            r_z       <= 1'b1;
            r_p       <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_conflict || w_timeout) begin
                r_bus_err <= 1'b1;
            end
            if (w_rd_done) begin
                r_mdr <= mem.mem_rdata;
            end
            if (w_idle) begin
                if (i_ldPC) begin
                    unique case (pc_sel_e'(i_selPC))
                        PcInc:  r_pc <= r_pc + 1'b1;
                        PcEab:  r_pc <= w_eab;
                        PcBus:  r_pc <= w_bus;
                        PcHold: r_pc <= r_pc;
                    endcase
                end
                if (i_ldIR) begin
                    r_ir <= w_bus;
                end
                if (i_ldMAR) begin
                    r_mar <= w_bus;
                end
                if (i_ldMDR && !i_selMDR) begin
                    r_mdr <= w_bus;
                end
                if (i_flagWE) begin
                    r_n <= w_bus[DW-1];
                    r_z <= (w_bus == '0);
                    r_p <= !w_bus[DW-1] && (w_bus != '0);
                end
            end
        end
    end

    assign mem.mem_req   = (r_state == StAccess);
    assign mem.mem_we    = (r_state == StAccess) && r_wr;
    assign mem.mem_addr  = r_mar;
    assign mem.mem_wdata = r_mdr;

    assign o_busy    = (r_state == StAccess);
    assign o_IR_out  = r_ir;
    assign o_N       = r_n;
    assign o_Z       = r_z;
    assign o_P       = r_p;
    // A conflict is flagged in the very cycle it happens, then held.
    assign o_bus_err = r_bus_err || w_conflict;

endmodule

// File: tb/tb_lc3_datapath_gen.sv
// Bench for lc3_datapath_gen: directed scenarios plus randomized micro-ops
// checked against an architectural model; a second 32-bit/16-register
// instance covers the wide configuration.
module tb_lc3_datapath_gen;

    localparam int E_ALU = 8, E_MARM = 4, E_PC = 2, E_MDR = 1;
    localparam int L_REG = 32, L_FLG = 16, L_PC = 8, L_IR = 4, L_MAR = 2, L_MDR = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 16-bit instance stimulus
    logic [1:0] alu_s, sel_pc, sel_eab2;
    logic [2:0] sr1_s, sr2_s, dr_s;
    logic sel_eab1, sel_mar, sel_mdr;
    logic ena_alu, ena_marm, ena_pc, ena_mdr;
    logic reg_we, flag_we, ld_pc, ld_ir, ld_mar, ld_mdr, mem_we_s;
    logic [15:0] ir_out;
    logic n_o, z_o, p_o, busy, bus_err;

    lc3_datapath_gen_if #(.DW(16)) mem_if ();

    lc3_datapath_gen #(.DW(16), .NREG(8), .RAW(3), .TO(15)) dut (
        .clk(clk), .reset(reset), .i_aluControl(alu_s),
        .i_SR1(sr1_s), .i_SR2(sr2_s), .i_DR(dr_s),
        .i_selPC(sel_pc), .i_selEAB2(sel_eab2), .i_selEAB1(sel_eab1),
        .i_selMAR(sel_mar), .i_selMDR(sel_mdr),
        .i_enaALU(ena_alu), .i_enaMARM(ena_marm), .i_enaPC(ena_pc), .i_enaMDR(ena_mdr),
        .i_regWE(reg_we), .i_flagWE(flag_we), .i_ldPC(ld_pc), .i_ldIR(ld_ir),
        .i_ldMAR(ld_mar), .i_ldMDR(ld_mdr), .i_memWE(mem_we_s),
        .mem(mem_if),
        .o_IR_out(ir_out), .o_N(n_o), .o_Z(z_o), .o_P(p_o),
        .o_busy(busy), .o_bus_err(bus_err)
    );

    // 32-bit instance stimulus
    logic [1:0] b_alu;
    logic [3:0] b_sr1, b_sr2, b_dr;
    logic b_ena_alu, b_ena_pc, b_reg_we, b_flag_we, b_ld_pc, b_ld_ir;
    logic [31:0] b_ir;
    logic b_n, b_z, b_p, b_busy, b_err;

    lc3_datapath_gen_if #(.DW(32)) b_mem ();

    lc3_datapath_gen #(.DW(32), .NREG(16), .RAW(4), .TO(15)) dut32 (
        .clk(clk), .reset(reset), .i_aluControl(b_alu),
        .i_SR1(b_sr1), .i_SR2(b_sr2), .i_DR(b_dr),
        .i_selPC(2'b00), .i_selEAB2(2'b00), .i_selEAB1(1'b0),
        .i_selMAR(1'b0), .i_selMDR(1'b0),
        .i_enaALU(b_ena_alu), .i_enaMARM(1'b0), .i_enaPC(b_ena_pc), .i_enaMDR(1'b0),
        .i_regWE(b_reg_we), .i_flagWE(b_flag_we), .i_ldPC(b_ld_pc), .i_ldIR(b_ld_ir),
        .i_ldMAR(1'b0), .i_ldMDR(1'b0), .i_memWE(1'b0),
        .mem(b_mem),
        .o_IR_out(b_ir), .o_N(b_n), .o_Z(b_z), .o_P(b_p),
        .o_busy(b_busy), .o_bus_err(b_err)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Architectural model of the 16-bit instance
    logic [15:0] m_pc, m_ir, m_mar, m_mdr;
    logic [15:0] m_r [8];
    logic m_n, m_z, m_p, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sx(input int v, input int bits);
        int t;
        t = v;
        if (v >= (1 << (bits - 1))) t = v - (1 << bits);
        return 16'(t);
    endfunction

    task automatic clear_ctrl();
        alu_s = '0; sr1_s = '0; sr2_s = '0; dr_s = '0;
        sel_pc = '0; sel_eab2 = '0; sel_eab1 = 0; sel_mar = 0; sel_mdr = 0;
        ena_alu = 0; ena_marm = 0; ena_pc = 0; ena_mdr = 0;
        reg_we = 0; flag_we = 0; ld_pc = 0; ld_ir = 0; ld_mar = 0; ld_mdr = 0; mem_we_s = 0;
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0;
        for (int i = 0; i < 8; i++) m_r[i] = 0;
        m_n = 0; m_z = 1; m_p = 0; m_err = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        mem_if.mem_ack = 0;
        tick();
        tick();
        reset = 1;
        model_reset();
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_ir"}, 32'(ir_out), 32'(m_ir));
        chk({tag, "_n"}, 32'(n_o), 32'(m_n));
        chk({tag, "_z"}, 32'(z_o), 32'(m_z));
        chk({tag, "_p"}, 32'(p_o), 32'(m_p));
        chk({tag, "_err"}, 32'(bus_err), 32'(m_err));
    endtask

    // One idle-state micro-op: model predicts the bus, then state advances.
    task automatic uop(input int alu, input int sr1, input int sr2, input int dr,
                       input int spc, input int seab2, input int seab1, input int smar,
                       input int ena, input int ld);
        logic [15:0] ra, rb, opb, res, off, eab, mm, bus;
        int nen;
        ra = m_r[sr1];
        rb = m_r[sr2];
        opb = m_ir[5] ? sx(int'(m_ir[4:0]), 5) : rb;
        case (alu)
            0: res = ra + opb;
            1: res = ra & opb;
            2: res = ~ra;
            default: res = ra;
        endcase
        case (seab2)
            0: off = 16'h0;
            1: off = sx(int'(m_ir[5:0]), 6);
            2: off = sx(int'(m_ir[8:0]), 9);
            default: off = sx(int'(m_ir[10:0]), 11);
        endcase
        eab = ((seab1 != 0) ? ra : m_pc) + off;
        mm = (smar != 0) ? eab : {8'h00, m_ir[7:0]};
        nen = 0;
        for (int b = 0; b < 4; b++) if ((ena >> b) & 1) nen++;
        bus = 16'h0;
        if (nen == 1) begin
            if (ena & E_ALU) bus = res;
            else if (ena & E_MARM) bus = mm;
            else if (ena & E_PC) bus = m_pc;
            else bus = m_mdr;
        end
        alu_s = 2'(alu); sr1_s = 3'(sr1); sr2_s = 3'(sr2); dr_s = 3'(dr);
        sel_pc = 2'(spc); sel_eab2 = 2'(seab2); sel_eab1 = (seab1 != 0); sel_mar = (smar != 0);
        ena_alu = (ena & E_ALU) != 0; ena_marm = (ena & E_MARM) != 0;
        ena_pc = (ena & E_PC) != 0; ena_mdr = (ena & E_MDR) != 0;
        reg_we = (ld & L_REG) != 0; flag_we = (ld & L_FLG) != 0; ld_pc = (ld & L_PC) != 0;
        ld_ir = (ld & L_IR) != 0; ld_mar = (ld & L_MAR) != 0; ld_mdr = (ld & L_MDR) != 0;
        tick();
        clear_ctrl();
        if (ld & L_REG) m_r[dr] = bus;
        if (ld & L_FLG) begin
            m_n = bus[15];
            m_z = (bus == 0);
            m_p = !m_n && !m_z;
        end
        if (ld & L_PC) begin
            case (spc)
                0: m_pc = (m_pc == 16'hFFFF) ? 16'h0 : m_pc + 16'h1;
                1: m_pc = eab;
                2: m_pc = bus;
                default: m_pc = m_pc;
            endcase
        end
        if (ld & L_IR) m_ir = bus;
        if (ld & L_MAR) m_mar = bus;
        if (ld & L_MDR) m_mdr = bus;
        if (nen > 1) m_err = 1;
    endtask

    // Memory access acting as the slave; lat = 0 means never acknowledge.
    task automatic mem_access(input bit wr, input int lat, input logic [15:0] data,
                              input bit noisy, input int exp_cnt);
        int cnt;
        bit done;
        clear_ctrl();
        if (wr) mem_we_s = 1;
        else begin
            ld_mdr = 1;
            sel_mdr = 1;
        end
        tick();
        clear_ctrl();
        cnt = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (!busy) done = 1;
            else begin
                cnt++;
                if (cnt == 1) begin
                    chk("acc_req", 32'(mem_if.mem_req), 32'd1);
                    chk("acc_we", 32'(mem_if.mem_we), 32'(wr));
                    chk("acc_addr", 32'(mem_if.mem_addr), 32'(m_mar));
                    if (wr) chk("acc_wdata", 32'(mem_if.mem_wdata), 32'(m_mdr));
                end
                if (noisy) begin
                    alu_s = 2'd2; sr1_s = 3'd0; ena_alu = 1; ld_ir = 1; ld_pc = 1;
                    sel_pc = 2'd2; reg_we = 1; dr_s = 3'd1; flag_we = 1; ld_mar = 1;
                end
                mem_if.mem_rdata = 16'($urandom);
                if (cnt == lat) begin
                    mem_if.mem_ack = 1;
                    mem_if.mem_rdata = data;
                end
                tick();
                mem_if.mem_ack = 0;
                clear_ctrl();
            end
        end
        chk("busy_cycles", 32'(cnt), 32'(exp_cnt));
        if (lat >= 1 && lat <= 15) begin
            if (!wr) m_mdr = data;
        end else begin
            m_err = 1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, ena;
        clear_ctrl();
        mem_if.mem_ack = 0;
        mem_if.mem_rdata = 0;
        b_mem.mem_ack = 0;
        b_mem.mem_rdata = 0;
        b_alu = 0; b_sr1 = 0; b_sr2 = 0; b_dr = 0;
        b_ena_alu = 0; b_ena_pc = 0; b_reg_we = 0; b_flag_we = 0; b_ld_pc = 0; b_ld_ir = 0;
        reset = 0;

        do_reset();
        chk("rst_ir", 32'(ir_out), 32'd0);
        chk("rst_n", 32'(n_o), 32'd0);
        chk("rst_z", 32'(z_o), 32'd1);
        chk("rst_p", 32'(p_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(mem_if.mem_req), 32'd0);
        chk("rst_we", 32'(mem_if.mem_we), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);

        // PC counts up to 5, then lands in IR
        repeat (5) uop(0, 0, 0, 0, 0, 0, 0, 0, 0, L_PC);
        uop(0, 0, 0, 0, 0, 0, 0, 0, E_PC, L_IR);
        chk("pc5", 32'(ir_out), 32'h5);

        // Acknowledge while idle must not touch MDR
        mem_if.mem_ack = 1;
        mem_if.mem_rdata = 16'h1234;
        tick();
        mem_if.mem_ack = 0;
        uop(0, 0, 0, 0, 0, 0, 0, 0, E_MDR, L_IR);
        chk("idle_ack_ignored", 32'(ir_out), 32'h0);

        // Single-cycle read, then IR = 0x003D
        mem_access(0, 1, 16'h003D, 0, 1);
        uop(0, 0, 0, 0, 0, 0, 0, 0, E_MDR, L_IR);
        chk("rd1_ir", 32'(ir_out), 32'h003D);

        // R1 = 5; R2 = R1 + imm(-3) with flags
        uop(0, 0, 0, 1, 0, 0, 0, 0, E_PC, L_REG);
        uop(0, 1, 0, 2, 0, 0, 0, 0, E_ALU, L_REG | L_FLG);
        chk("add_n", 32'(n_o), 32'd0);
        chk("add_z", 32'(z_o), 32'd0);
        chk("add_p", 32'(p_o), 32'd1);
        uop(3, 2, 0, 0, 0, 0, 0, 0, E_ALU, L_IR);
        chk("add_r2", 32'(ir_out), 32'h0002);
        chk_state("add");

        // MAR = zext IR[7:0] = 2, fetch 0x3000 into MAR, then 3-cycle read
        uop(0, 0, 0, 0, 0, 0, 0, 0, E_MARM, L_MAR);
        mem_access(0, 1, 16'h3000, 0, 1);
        uop(0, 0, 0, 0, 0, 0, 0, 0, E_MDR, L_MAR);
        mem_access(0, 3, 16'hBEEF, 0, 3);
        uop(0, 0, 0, 0, 0, 0, 0, 0, E_MDR, L_IR);
        chk("ir_beef", 32'(ir_out), 32'hBEEF);

        // Write with 2-cycle ack
        mem_access(1, 2, 16'h0, 0, 2);

        // Read timeout with strobes hammered while busy
        mem_access(0, 0, 16'h0, 1, 15);
        chk("to_err", 32'(bus_err), 32'd1);
        chk_state("to_ignored");
        uop(0, 0, 0, 0, 0, 0, 0, 0, E_PC, L_IR);
        chk("to_pc_held", 32'(ir_out), 32'h5);
        uop(0, 0, 0, 0, 0, 0, 0, 0, E_MDR, L_IR);
        chk("to_mdr", 32'(ir_out), 32'hBEEF);

        // Reset in the middle of an access
        ld_mdr = 1;
        sel_mdr = 1;
        tick();
        clear_ctrl();
        tick();
        chk("mid_req", 32'(mem_if.mem_req), 32'd1);
        reset = 0;
        tick();
        chk("mid_rst_req", 32'(mem_if.mem_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_z", 32'(z_o), 32'd1);
        chk("mid_rst_err", 32'(bus_err), 32'd0);
        chk("mid_rst_ir", 32'(ir_out), 32'd0);
        reset = 1;
        model_reset();

        // PC = 0xFFFF via bus, then increment wraps to 0
        uop(2, 0, 0, 0, 2, 0, 0, 0, E_ALU, L_PC | L_IR | L_FLG);
        chk("not_ir", 32'(ir_out), 32'hFFFF);
        chk("not_n", 32'(n_o), 32'd1);
        uop(0, 0, 0, 0, 0, 0, 0, 0, 0, L_PC);
        uop(0, 0, 0, 0, 0, 0, 0, 0, E_PC, L_IR | L_FLG);
        chk("pc_wrap", 32'(ir_out), 32'h0);
        chk("pc_wrap_z", 32'(z_o), 32'd1);

        // Two bus drivers: bus reads 0, error sticks until reset
        uop(2, 0, 0, 0, 0, 0, 0, 0, E_ALU, L_IR);
        uop(2, 0, 0, 0, 0, 0, 0, 0, E_ALU | E_PC, L_IR);
        chk("conf_ir", 32'(ir_out), 32'h0);
        chk("conf_err", 32'(bus_err), 32'd1);
        repeat (5) tick();
        chk("conf_sticky", 32'(bus_err), 32'd1);
        chk_state("conf");
        do_reset();
        chk("conf_cleared", 32'(bus_err), 32'd0);

        // Randomized single-driver micro-ops
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 4));
            ena = (r == 0) ? 0 : (1 << (r - 1));
            uop(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                ena, int'($urandom_range(0, 63)));
            chk_state("rnd");
        end

        // Wide configuration: R15 = 1 doubled 31 times
        do_reset();
        chk("w_rst_z", 32'(b_z), 32'd1);
        b_ld_pc = 1;
        tick();
        b_ld_pc = 0;
        b_ena_pc = 1; b_reg_we = 1; b_dr = 4'd15;
        tick();
        b_ena_pc = 0;
        b_ena_alu = 1; b_alu = 2'd0; b_sr1 = 4'd15; b_sr2 = 4'd15;
        for (int i = 0; i < 31; i++) begin
            b_flag_we = (i == 30);
            tick();
        end
        b_reg_we = 0;
        b_flag_we = 0;
        chk("w_n", 32'(b_n), 32'd1);
        chk("w_z", 32'(b_z), 32'd0);
        chk("w_p", 32'(b_p), 32'd0);
        b_alu = 2'd3;
        b_ld_ir = 1;
        tick();
        b_ld_ir = 0;
        b_ena_alu = 0;
        chk("w_r15", b_ir, 32'h8000_0000);
        chk("w_err", 32'(b_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
